hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage pipelined CPU. It drives PC-write, IF/ID-write, ID/EX-bubble and the IF/ID, ID/EX and EX/MEM flush controls. It covers four cases: load-use and flag-use stalls, taken-branch squash, post-reset drain, and an external halt/resume handshake. The block sits beside the forwarding unit, takes its hazard inputs from the ID, EX and MEM stages, and owns no datapath.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, branch squash, post-reset drain, halt/resume.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_req,
    input  logic [4:0]  Rn_id,
    input  logic [4:0]  Ab_id,
    input  logic        uses_rn_id,
    input  logic        uses_ab_id,
    input  logic        cond_id,
    input  logic        MemtoReg_ex,
    input  logic        RegWrite_ex,
    input  logic [4:0]  Rd_ex,
    input  logic        update_ex,
    input  logic        BrTaken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam logic [1:0] ST_DRAIN   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HALTING = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] HALT_LOAD  = 4'd2;

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] w_next_state;
    logic [3:0] w_next_cnt;
    logic       w_load_use;
    logic       w_flag_use;
    logic       w_stall;

    assign w_load_use = MemtoReg_ex & RegWrite_ex & (Rd_ex != 5'd31) &
                        ((uses_rn_id & (Rn_id == Rd_ex)) | (uses_ab_id & (Ab_id == Rd_ex)));
    assign w_flag_use = cond_id & update_ex;
    assign w_stall    = w_load_use | w_flag_use;

    assign state = r_state;

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end
            ST_RUN: begin
                // A halt request takes effect in its own cycle, so it behaves like HALTING.
                if (halt_req) begin
                    if (BrTaken) begin
                        pc_write     = 1'b1;
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                    end
                end else if (BrTaken) begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    id_ex_bubble = 1'b0;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end else if (!w_stall) begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    id_ex_bubble = 1'b0;
                end
            end
            ST_HALTING: begin
                if (BrTaken) begin
                    pc_write     = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_DRAIN: begin
                if (r_cnt == 4'd0) w_next_state = ST_RUN;
                else               w_next_cnt   = r_cnt - 4'd1;
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_next_state = ST_HALTING;
                    w_next_cnt   = HALT_LOAD;
                end
            end
            ST_HALTING: begin
                if (r_cnt == 4'd0) w_next_state = ST_HALTED;
                else               w_next_cnt   = r_cnt - 4'd1;
            end
            default: begin
                if (!halt_req) w_next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_DRAIN;
            r_cnt   <= DRAIN_LOAD;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_inc;
    logic        w_flush_inc;

    assign w_stall_inc = (r_state == ST_RUN) & ~halt_req & ~BrTaken & w_stall;
    assign w_flush_inc = BrTaken & ((r_state == ST_RUN) | (r_state == ST_HALTING));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
